// File: rtl/muldiv_iter_32.sv
// Iterative 32x32 multiply / restoring divide with start/busy/done handshake.
// Define MULDIV_SIGNED_EN to enable two's-complement operation selected by op[1].
module muldiv_iter_32 #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one shift-add / shift-subtract step per cycle
    // FIN   | hi/lo valid, done pulse; a new start is accepted here too
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_hi_d;
    logic [WIDTH-1:0] step_lo_d;
    logic [WIDTH-1:0] res_hi_d;
    logic [WIDTH-1:0] res_lo_d;

`ifdef MULDIV_SIGNED_EN
    logic             neg_main_q;
    logic             neg_rem_q;
    logic             neg_main_d;
    logic             neg_rem_d;
    logic [2*WIDTH-1:0] prod_fix;

    // Operands iterate as magnitudes; signs are restored when hi/lo are registered.
    always_comb begin
        a_mag      = (op[1] && a[WIDTH-1]) ? -a : a;
        b_mag      = (op[1] && b[WIDTH-1]) ? -b : b;
        neg_main_d = op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_d  = op[1] & op[0] & a[WIDTH-1];
    end

    always_comb begin
        prod_fix = {step_hi_d, step_lo_d};
        res_hi_d = step_hi_d;
        res_lo_d = step_lo_d;
        if (is_div_q) begin
            if (neg_main_q) res_lo_d = -step_lo_d;
            if (neg_rem_q)  res_hi_d = -step_hi_d;
        end else if (neg_main_q) begin
            prod_fix = -{step_hi_d, step_lo_d};
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_d = prod_fix[WIDTH-1:0];
        end
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1];
    assign a_mag    = a;
    assign b_mag    = b;
    assign res_hi_d = step_hi_d;
    assign res_lo_d = step_lo_d;
`endif

    // Both operations share the {acc_hi, acc_lo} pair: multiplier / dividend starts in acc_lo.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, operand_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                step_hi_d = div_trial[WIDTH-1:0];
                step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_d = div_shift[WIDTH-1:0];
                step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_d = mul_sum[WIDTH:1];
            step_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            operand_q <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        is_div_q  <= op[0];
                        operand_q <= b_mag;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= a_mag;
                        cnt_q     <= '0;
`ifdef MULDIV_SIGNED_EN
                        neg_main_q <= neg_main_d;
                        neg_rem_q  <= neg_rem_d;
`endif
                        if (op[0] && (b == '0)) begin
                            // Divide by zero completes without iterating; hi carries the raw dividend.
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            hi_q    <= a;
                            lo_q    <= '1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= res_hi_d;
                        lo_q    <= res_lo_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/muldiv_iter_32.md
Name: muldiv_iter_32

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage.
- Produces the 64-bit hi/lo result. The lo word feeds the existing 32-bit zero-detect stage downstream, which raises the zero flag when lo equals 0.
- Multi-cycle operation uses a start/busy/done handshake so the control unit can stall the PC while the unit is busy.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; hi/lo are each WIDTH bits.
- ITER, 32, number of iteration cycles. Must equal WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled on rising clk
- op  input  2  op[0]: 0 = multiply, 1 = divide. op[1]: signed select (used only with MULDIV_SIGNED_EN)
- a  input  32  multiplicand / dividend
- b  input  32  multiplier / divisor
- busy  output  1  high while an operation is iterating
- done  output  1  one-cycle pulse when hi/lo become valid
- div_by_zero  output  1  high together with done when a divide had b = 0
- hi  output  32  product[63:32] / remainder
- lo  output  32  product[31:0] / quotient

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, div_by_zero = 0.
  - hi = 0, lo = 0, iteration counter = 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - start = 1 latches a, b and op, loads the internal accumulator and counter = 0, and goes to RUN.
  - Exception: divide with b = 0 goes directly to FIN.
- RUN:
  - busy = 1.
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter increments.
  - When counter = 31 at a rising edge, that step completes and the state goes to FIN.
  - start is ignored in RUN. Inputs a, b and op may change freely after the accept cycle.
- FIN:
  - busy = 0, done = 1 for exactly one cycle.
  - hi/lo are registered on entry to FIN and hold until the next accepted start completes.
  - Next state is IDLE.
  - A start asserted in FIN is accepted: the state goes straight to RUN, as if from IDLE.
- Latency: start accepted at edge N; busy = 1 for cycles N+1 .. N+32; done = 1 in cycle N+33.
- Divide-by-zero:
  - Takes 1 cycle: done = 1 in cycle N+1.
  - div_by_zero = 1 in that same cycle.
  - lo = 32'hFFFF_FFFF, hi = a.
- div_by_zero is 0 whenever done = 0.
- Multiply arithmetic: unsigned 32x32 -> 64. No overflow indication; the full product is always held in hi:lo.
- Divide arithmetic: unsigned restoring division. lo = floor(a/b), hi = a mod b.
- hi/lo never change outside the FIN entry edge, except on reset.
- Reset asserted mid-RUN:
  - Aborts immediately; all outputs return to reset values.
  - No done is produced for the aborted operation.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op[1] = 1 selects two's-complement signed operation.
  - Operands are converted to magnitudes at accept; the sign is fixed up combinationally when registering into hi/lo at FIN entry. Latency is unchanged.
  - Signed multiply: 64-bit product is negated if sign(a) != sign(b).
  - Signed divide: quotient is negated if sign(a) != sign(b); remainder takes the sign of a.
  - 32'h8000_0000 / 32'hFFFF_FFFF gives lo = 32'h8000_0000, hi = 0, done after 32 cycles, div_by_zero = 0.
  - Signed divide-by-zero behaves as the unsigned case (lo = all ones, hi = a).
- Not defined: op[1] is ignored and all operations are unsigned. No sign logic is synthesized.

Test Plan:
- Reset/idle: hold rst_n = 0 for 3 cycles, then release. Required: busy = 0, done = 0, hi = lo = 0, no done pulse while start = 0.
- Unsigned multiply: a = 32'hFFFF_FFFF, b = 32'h0000_0002, op = 00, start at edge N. Required: busy high N+1..N+32; done = 1 in N+33 only; hi = 32'h0000_0001, lo = 32'hFFFF_FFFE.
- Unsigned divide: a = 100, b = 7, op = 01. Required: done at N+33, lo = 14, hi = 2, div_by_zero = 0. Also a = 5, b = 10: lo = 0, so the downstream zero flag = 1.
- Divide by zero: a = 32'h1234_5678, b = 0, op = 01. Required: done and div_by_zero both 1 at N+1; lo = 32'hFFFF_FFFF, hi = 32'h1234_5678.
- Handshake:
  - start held high throughout a multiply: only one operation runs; the second operation is accepted in the FIN cycle.
  - Drop rst_n at cycle N+10 of a divide: outputs return to 0 at once, and no done pulse follows.
- Signed ops (with MULDIV_SIGNED_EN):
  - a = -7, b = 2, op = 11: lo = -3 (32'hFFFF_FFFD), hi = -1.
  - a = -3, b = 4, op = 10: hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFF4.
  - Without the macro, the same op = 11 operands give the unsigned results.
